// File: rtl/imem_loader.sv
// Instruction memory loader: streams 32-bit words into a byte-wide
// write port, most significant byte at the lowest address.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_word,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  typedef enum logic [1:0] {
    IDLE,
    ACCEPT,
    WRITE,
    DONE
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] TOP   = '1;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  rem;
  logic [1:0]        idx;
  logic [31:0]       word;

  assign in_ready = (state == ACCEPT);
  assign mem_addr = addr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      addr      <= '0;
      rem       <= '0;
      idx       <= '0;
      word      <= '0;
      mem_we    <= 1'b0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            if (word_count != '0) begin
              addr  <= base_addr & ALIGN;
              rem   <= word_count;
              busy  <= 1'b1;
              state <= ACCEPT;
            end else begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        ACCEPT: begin
          if (in_valid) begin
            // word shifts left so the next byte is always at [23:16]
            word      <= in_word;
            mem_wdata <= in_word[31:24];
            mem_we    <= 1'b1;
            idx       <= '0;
            state     <= WRITE;
          end
        end
        WRITE: begin
          addr <= addr + 1'b1;
          if (idx != 2'd3) begin
            idx       <= idx + 1'b1;
            mem_wdata <= word[23:16];
            word      <= {word[23:0], 8'h00};
          end else begin
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            rem       <= rem - 1'b1;
            if (rem == CNT_W'(1)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else if (addr == TOP) begin
              overflow <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end else begin
              state <= ACCEPT;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: table of loads, byte-write scoreboard,
// memory model for fetch read-back, plus a mid-word reset sequence.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [6:0]  word_count;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_word;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        busy;
  logic        done;
  logic        overflow;

  imem_loader #(.ADDR_W(8), .CNT_W(7)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .base_addr  (base_addr),
    .word_count (word_count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_word    (in_word),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  base;
    int          cnt;
    int          stall;
    logic [31:0] w0;
    logic [31:0] w1;
  } vec_t;

  vec_t        tbl[5];
  logic [15:0] sb[$];
  logic [7:0]  tbmem[256];
  int          vecs = 0;
  int          errs = 0;
  bit          last_ovf = 1'b0;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask

  always @(posedge clk)
    if (mem_we) tbmem[mem_addr] <= mem_wdata;

  always @(negedge clk) begin
    if (reset_n && mem_we) begin
      if (sb.size() == 0) begin
        vecs++;
        errs++;
        $display("FAIL extra_write: got addr %h data %h expected none",
                 mem_addr, mem_wdata);
      end else begin
        chk("write", {16'h0, mem_addr, mem_wdata}, {16'h0, sb.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_load(input vec_t v);
    logic [31:0] words[$];
    logic [7:0]  addrs[$];
    logic [7:0]  a;
    logic [31:0] w;
    int          nacc;
    bit          ovf;
    int          t;
    int          dc;
    int          rdy;
    chk("ovf_hold", {31'h0, overflow}, {31'h0, last_ovf});
    a    = v.base & 8'hFC;
    nacc = 0;
    ovf  = 1'b0;
    for (int k = 0; k < v.cnt; k++) begin
      addrs.push_back(a);
      a = a + 8'd4;
      nacc++;
      if (k == v.cnt - 1) break;
      if (a == 8'h00) begin
        ovf = 1'b1;
        break;
      end
    end
    start      = 1'b1;
    base_addr  = v.base;
    word_count = 7'(v.cnt);
    step();
    start = 1'b0;
    for (int k = 0; k < nacc; k++) begin
      w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : $urandom;
      words.push_back(w);
      t = 0;
      while (!in_ready && t < 40) begin
        step();
        t++;
      end
      chk("accept_rdy", {31'h0, in_ready}, 32'h1);
      if (k > 0) begin
        for (int s = 0; s < v.stall; s++) begin
          start      = 1'b1;
          word_count = 7'd5;
          chk("stall_rdy", {31'h0, in_ready}, 32'h1);
          chk("stall_we", {31'h0, mem_we}, 32'h0);
          step();
        end
        start = 1'b0;
      end
      for (int b = 0; b < 4; b++)
        sb.push_back({addrs[k] + 8'(b), 8'(w >> (24 - 8 * b))});
      in_valid = 1'b1;
      in_word  = w;
      step();
      in_valid = 1'b0;
    end
    if (ovf) begin
      in_valid = 1'b1;
      in_word  = 32'hDEADBEEF;
    end
    dc  = 0;
    rdy = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) dc++;
      if (in_ready) rdy++;
      step();
    end
    in_valid = 1'b0;
    chk("done_pulse", dc, 1);
    chk("late_ready", rdy, 0);
    chk("overflow", {31'h0, overflow}, {31'h0, ovf});
    chk("busy_end", {31'h0, busy}, 32'h0);
    chk("sb_empty", sb.size(), 0);
    for (int k = 0; k < nacc; k++)
      chk("fetch", {tbmem[addrs[k]], tbmem[addrs[k] + 8'd1],
                    tbmem[addrs[k] + 8'd2], tbmem[addrs[k] + 8'd3]},
          words[k]);
    last_ovf = ovf;
  endtask

  initial begin
    tbl[0] = '{8'h10, 1, 0, 32'hE3A01005, 32'h0};
    tbl[1] = '{8'h23, 2, 3, 32'h11223344, 32'hAABBCCDD};
    tbl[2] = '{8'hF8, 3, 0, 32'h01234567, 32'h89ABCDEF};
    tbl[3] = '{8'h40, 0, 0, 32'h0, 32'h0};
    tbl[4] = '{8'h00, 64, 0, 32'hCAFEF00D, 32'h13579BDF};

    reset_n    = 1'b0;
    start      = 1'b0;
    base_addr  = '0;
    word_count = '0;
    in_valid   = 1'b0;
    in_word    = '0;
    repeat (3) step();
    reset_n = 1'b1;
    step();
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_ready", {31'h0, in_ready}, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_ovf", {31'h0, overflow}, 32'h0);

    for (int i = 0; i < 4; i++) run_load(tbl[i]);

    start      = 1'b1;
    base_addr  = 8'h40;
    word_count = 7'd1;
    step();
    start = 1'b0;
    chk("mid_rdy", {31'h0, in_ready}, 32'h1);
    sb.push_back({8'h40, 8'h5A});
    sb.push_back({8'h41, 8'hA5});
    in_valid = 1'b1;
    in_word  = 32'h5AA5C33C;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("mid_addr", {24'h0, mem_addr}, 32'h42);
    chk("mid_we", {31'h0, mem_we}, 32'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_we", {31'h0, mem_we}, 32'h0);
    chk("mid_rst_busy", {31'h0, busy}, 32'h0);
    chk("mid_rst_ready", {31'h0, in_ready}, 32'h0);
    step();
    step();
    reset_n = 1'b1;
    step();
    step();
    chk("post_rst_ready", {31'h0, in_ready}, 32'h0);
    chk("post_rst_sb", sb.size(), 0);
    chk("post_rst_b1", {24'h0, tbmem[8'h41]}, 32'hA5);
    last_ovf = 1'b0;

    run_load(tbl[4]);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
